// File: rtl/game_ctrl.sv
// game_ctrl: flap-button synchroniser/debouncer, IDLE/PLAY/PAUSE/DEAD sequencer and session high score.
// Optional feature: define GAME_CTRL_HISCORE_EN to build the high-score register (otherwise tied to 0).
module game_ctrl #(
    parameter logic [19:0] DEB_CYCLES = 20'd500000,
    parameter logic [25:0] DEAD_HOLD  = 26'd50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       pause_sw,
    input  logic       isDead,
    input  logic [7:0] score,
    output logic [1:0] state,
    output logic       up_button,
    output logic       restart,
    output logic [7:0] high_score
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        DEAD  = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t      r_state, w_next;
    logic        r_s1, r_s2, r_deb, r_deb_q, r_press, r_restart;
    logic [19:0] r_cnt;
    logic [25:0] r_hold;
    logic        w_to_dead, w_to_idle;

    // Level is accepted only after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= btn_raw;
            r_s2    <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_CYCLES - 20'd1) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
            r_deb_q <= r_deb;
            r_press <= r_deb & ~r_deb_q;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_to_dead = 1'b0;
        w_to_idle = 1'b0;
        case (r_state)
            IDLE:  if (r_press) w_next = PLAY;
            PLAY: begin
                if (isDead) begin
                    w_next    = DEAD;
                    w_to_dead = 1'b1;
                end else if (pause_sw) begin
                    w_next = PAUSE;
                end
            end
            PAUSE: if (!pause_sw) w_next = PLAY;
            DEAD: begin
                if (r_hold == '0 && r_press) begin
                    w_next    = IDLE;
                    w_to_idle = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Hold counter is only meaningful while DEAD; it is reloaded on every entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_hold    <= '0;
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_restart <= w_to_idle;
            if (w_to_dead)
                r_hold <= DEAD_HOLD - 26'd1;
            else if (r_state == DEAD && r_hold != '0)
                r_hold <= r_hold - 26'd1;
        end
    end

    assign state     = r_state;
    assign up_button = r_press && (r_state == PLAY);
    assign restart   = r_restart;

`ifdef GAME_CTRL_HISCORE_EN
    logic [7:0] r_high;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_high <= 8'd0;
        else if (w_to_dead && score > r_high)
            r_high <= score;
    end

    assign high_score = r_high;
`else
    logic w_unused_score;

    assign w_unused_score = ^score;
    assign high_score     = 8'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenario tasks plus randomized run against a behavioural model.
module tb_game_ctrl;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef GAME_CTRL_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, btn_raw, pause_sw, isDead;
    logic [7:0] score;
    logic [1:0] state;
    logic       up_button, restart;
    logic [7:0] high_score;

    int n_checks = 0;
    int n_pass   = 0;

    game_ctrl #(.DEB_CYCLES(20'd4), .DEAD_HOLD(26'd8)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .pause_sw(pause_sw),
        .isDead(isDead), .score(score), .state(state), .up_button(up_button),
        .restart(restart), .high_score(high_score)
    );

    always #5 clk = ~clk;

    // Behavioural model: debounced level flips once the last DEB synchronised samples all differ from it;
    // DEAD exit is allowed once DEAD_HOLD edges have elapsed since entry.
    logic       m_r1, m_r2, m_deb, m_debq, m_press, m_restart, m_nd, m_all, m_nrst;
    logic [1:0] m_state, m_ns;
    logic [7:0] m_hs;
    int         m_dead_edges;
    bit         hist[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_r1 = 0; m_r2 = 0; m_deb = 0; m_debq = 0; m_press = 0; m_restart = 0;
            m_state = 2'b00; m_hs = 8'd0; m_dead_edges = 0;
            hist.delete();
        end else begin
            hist.push_back(m_r2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_all = (hist.size() == DEB);
            foreach (hist[j]) if (hist[j] == m_deb) m_all = 0;
            m_nd = m_all ? ~m_deb : m_deb;
            m_ns = m_state;
            m_nrst = 0;
            case (m_state)
                2'b00: if (m_press) m_ns = 2'b01;
                2'b01: if (isDead) m_ns = 2'b10; else if (pause_sw) m_ns = 2'b11;
                2'b11: if (!pause_sw) m_ns = 2'b01;
                default: if (m_dead_edges + 1 >= HOLD && m_press) begin m_ns = 2'b00; m_nrst = 1; end
            endcase
            if (HS_EN && m_state == 2'b01 && m_ns == 2'b10 && score > m_hs) m_hs = score;
            if (m_state == 2'b10) m_dead_edges = m_dead_edges + 1;
            else if (m_ns == 2'b10) m_dead_edges = 0;
            m_press = m_deb & ~m_debq;
            m_debq = m_deb;
            m_deb = m_nd;
            m_r2 = m_r1;
            m_r1 = btn_raw;
            m_state = m_ns;
            m_restart = m_nrst;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; btn_raw = 0; pause_sw = 0; isDead = 0; score = 0;
        cyc(2);
        rst_n = 1;
    endtask

    task automatic tap();
        btn_raw = 1; cyc(10);
        btn_raw = 0; cyc(10);
    endtask

    task automatic test_reset();
        logic [1:0] exp_st;
        rst_n = 0; btn_raw = 1; pause_sw = 0; isDead = 0; score = 8'd99;
        cyc(2);
        n_checks++; if (state !== 2'b00) $display("FAIL reset_state got %0h want 0", state); else n_pass++;
        n_checks++; if (up_button !== 1'b0) $display("FAIL reset_up got %0b want 0", up_button); else n_pass++;
        n_checks++; if (restart !== 1'b0) $display("FAIL reset_restart got %0b want 0", restart); else n_pass++;
        n_checks++; if (high_score !== 8'd0) $display("FAIL reset_hs got %0d want 0", high_score); else n_pass++;
        rst_n = 1;
        // Press lands after edge DEB+3; state follows one edge later.
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            exp_st = (k >= DEB + 4) ? 2'b01 : 2'b00;
            n_checks++;
            if (state !== exp_st || up_button !== 1'b0)
                $display("FAIL reset_first_press edge %0d got st=%0h up=%0b want st=%0h up=0", k, state, up_button, exp_st);
            else n_pass++;
        end
        btn_raw = 0; score = 0;
        cyc(10);
    endtask

    task automatic test_debounce();
        int ups = 0, first = 0;
        btn_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 3) btn_raw = 0;
            if (up_button) ups++;
        end
        n_checks++; if (ups != 0) $display("FAIL deb_short_glitch got %0d ups want 0", ups); else n_pass++;
        ups = 0;
        btn_raw = 1;
        for (int i = 1; i <= 25; i++) begin
            cyc(1);
            if (i == 10) btn_raw = 0;
            if (up_button) begin ups++; if (first == 0) first = i; end
        end
        n_checks++; if (ups != 1) $display("FAIL deb_long_count got %0d want 1", ups); else n_pass++;
        n_checks++; if (first != DEB + 3) $display("FAIL deb_long_edge got %0d want %0d", first, DEB + 3); else n_pass++;
        n_checks++; if (state !== 2'b01) $display("FAIL deb_state got %0h want 1", state); else n_pass++;
    endtask

    task automatic test_start_flap();
        int ups = 0;
        do_reset();
        btn_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 10) btn_raw = 0;
            if (up_button) ups++;
        end
        n_checks++; if (state !== 2'b01) $display("FAIL start_state got %0h want 1", state); else n_pass++;
        n_checks++; if (ups != 0) $display("FAIL start_no_flap got %0d want 0", ups); else n_pass++;
        ups = 0;
        btn_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 10) btn_raw = 0;
            if (up_button) ups++;
        end
        n_checks++; if (ups != 1) $display("FAIL flap_count got %0d want 1", ups); else n_pass++;
    endtask

    task automatic test_pause();
        int ups = 0, bad = 0;
        pause_sw = 1;
        cyc(1);
        n_checks++; if (state !== 2'b11) $display("FAIL pause_enter got %0h want 3", state); else n_pass++;
        btn_raw = 1; isDead = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 10) btn_raw = 0;
            if (up_button) ups++;
            if (state !== 2'b11) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL pause_hold got %0d cycles out of pause want 0", bad); else n_pass++;
        n_checks++; if (ups != 0) $display("FAIL pause_no_flap got %0d want 0", ups); else n_pass++;
        pause_sw = 0;
        cyc(1);
        n_checks++; if (state !== 2'b01) $display("FAIL pause_exit got %0h want 1", state); else n_pass++;
        cyc(1);
        n_checks++; if (state !== 2'b10) $display("FAIL pause_then_dead got %0h want 2", state); else n_pass++;
        isDead = 0;
    endtask

    task automatic test_death();
        int bad = 0, rsts = 0;
        logic [1:0] exp_st;
        do_reset();
        tap();
        score = 8'd20; isDead = 1;
        cyc(1);
        isDead = 0;
        n_checks++; if (high_score !== (HS_EN ? 8'd20 : 8'd0)) $display("FAIL hs_first got %0d", high_score); else n_pass++;
        cyc(HOLD);
        tap();
        n_checks++; if (state !== 2'b00) $display("FAIL dead_to_idle got %0h want 0", state); else n_pass++;
        tap();
        // Button rises with the death: its press is sampled one edge before the hold expires.
        score = 8'd37; isDead = 1; btn_raw = 1;
        cyc(1);
        isDead = 0;
        n_checks++; if (state !== 2'b10) $display("FAIL death_state got %0h want 2", state); else n_pass++;
        n_checks++; if (high_score !== (HS_EN ? 8'd37 : 8'd0)) $display("FAIL hs_update got %0d", high_score); else n_pass++;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            if (i == 9) btn_raw = 0;
            if (state !== 2'b10) bad++;
            if (restart) rsts++;
        end
        n_checks++; if (bad != 0 || rsts != 0) $display("FAIL hold_drop got %0d exits %0d restarts want 0", bad, rsts); else n_pass++;
        btn_raw = 1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (i == 10) btn_raw = 0;
            if (restart) rsts++;
        end
        n_checks++; if (rsts != 1) $display("FAIL restart_count got %0d want 1", rsts); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL restart_state got %0h want 0", state); else n_pass++;
        tap();
        // Press sampled exactly at edge DEAD_HOLD after entry must be accepted.
        score = 8'd12; isDead = 1;
        cyc(1);
        isDead = 0; btn_raw = 1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            exp_st = (k >= HOLD) ? 2'b00 : 2'b10;
            n_checks++;
            if (state !== exp_st || restart !== (k == HOLD))
                $display("FAIL hold_edge k=%0d got st=%0h rst=%0b want st=%0h rst=%0b", k, state, restart, exp_st, (k == HOLD));
            else n_pass++;
        end
        btn_raw = 0;
        n_checks++; if (high_score !== (HS_EN ? 8'd37 : 8'd0)) $display("FAIL hs_keep got %0d", high_score); else n_pass++;
        cyc(10);
    endtask

    task automatic test_random();
        int btn_left = 0;
        logic [11:0] act, exp;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            act = {state, up_button, restart, high_score};
            exp = {m_state, m_press && (m_state == 2'b01), m_restart, m_hs};
            n_checks++;
            if (act !== exp) $display("FAIL random cyc %0d got %03h want %03h", i, act, exp);
            else n_pass++;
            if (btn_left == 0) begin btn_raw = ~btn_raw; btn_left = $urandom_range(1, 12); end
            else btn_left--;
            if ($urandom_range(0, 29) == 0) pause_sw = ~pause_sw;
            isDead = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) score = 8'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_start_flap();
        test_pause();
        test_death();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
